// File: rtl/dvip_bram_pkg.sv
// Shared types and helpers for the DVP BRAM request bridge and its response FIFO.
package dvip_bram_pkg;

   localparam int BUS_DATA_W     = 32;
   localparam int BYTES_PER_WORD = BUS_DATA_W / 8;
   localparam int WIDX_SHIFT     = $clog2(BYTES_PER_WORD);

   typedef struct packed {
      logic [BUS_DATA_W-1:0] rdata;
      logic                  err;
      logic                  we;
   } rsp_t;

   // Expand each byte enable into eight identical bit strobes.
   function automatic logic [BUS_DATA_W-1:0] be2bitstrb(input logic [BYTES_PER_WORD-1:0] be);
      logic [BUS_DATA_W-1:0] strb;
      strb = '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         strb[i*8 +: 8] = {8{be[i]}};
      end
      return strb;
   endfunction

endpackage

// File: rtl/dvip_bram_rsp_fifo.sv
// Small in-order response FIFO; pointers wrap modulo DEPTH, empty head reads as zero.
module dvip_bram_rsp_fifo
   import dvip_bram_pkg::*;
#(
   parameter int  DEPTH = 3,
   parameter type T     = rsp_t,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  T                 push_data,
   input  logic             pop,
   output T                 pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T                 mem [DEPTH];
   T                 zero_entry;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign zero_entry = '0;
   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);
   assign do_push    = push & ~full;
   assign do_pop     = pop & ~empty;
   assign pop_data   = empty ? zero_entry : mem[rd_ptr];

   // Storage needs no reset; only the occupancy bookkeeping is cleared.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy update; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The upstream credit scheme must never let a push hit a full FIFO.
   assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/dvip_bram_req_bridge.sv
// Request stage in front of a DVP byte-write BRAM: range check, RAM drive, in-order responses.
module dvip_bram_req_bridge
   import dvip_bram_pkg::*;
#(
   parameter int  DATA_W    = BUS_DATA_W,
   parameter int  RAM_DEPTH = 1024,
   parameter int  ADDR_W    = 16,
   parameter int  RSP_DEPTH = 3,
   localparam int RAM_AW    = $clog2(RAM_DEPTH),
   localparam int BE_W      = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [BE_W-1:0]   req_be,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_we,
   output logic              ram_cs,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wstrb,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              ram_ready
);

   // DATA_W is expected to match the package bus width that rsp_t is built on.
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   logic [ADDR_W-1:0] widx;
   logic              oor;
   logic [CNT_W:0]    occupancy;
   logic              credit;
   logic              accept;
   logic              pend;
   logic              pend_we;
   logic              pend_oor;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   rsp_t              push_data;
   rsp_t              head;

   // The range check runs on the full-width word index so high address bits cannot alias.
   assign widx = req_addr >> WIDX_SHIFT;
   assign oor  = (widx >= ADDR_W'(RAM_DEPTH));

   // Credit counts the queued entries plus the one still waiting for RAM data.
   assign occupancy = (CNT_W+1)'(pend) + (CNT_W+1)'(count);
   assign credit    = (occupancy < (CNT_W+1)'(RSP_DEPTH)) & ~full;
   assign req_ready = ~rst & ram_ready & credit;
   assign accept    = req_valid & req_ready;

   // RAM pins follow the request directly; only chip select is qualified.
   assign ram_cs    = accept & ~oor;
   assign ram_addr  = widx[RAM_AW-1:0];
   assign ram_we    = req_we;
   assign ram_din   = req_wdata;
   assign ram_wstrb = be2bitstrb(req_be);

   // Remember what was accepted last cycle so the RAM read data can be paired with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend     <= 1'b0;
         pend_we  <= 1'b0;
         pend_oor <= 1'b0;
      end else begin
         pend     <= accept;
         pend_we  <= req_we;
         pend_oor <= oor;
      end
   end

   // Only in-range reads carry RAM data; writes and errors return zero.
   always_comb begin
      push_data       = '0;
      push_data.rdata = (~pend_we & ~pend_oor) ? ram_dout : '0;
      push_data.err   = pend_oor;
      push_data.we    = pend_we;
   end

   dvip_bram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .T     (rsp_t)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pend),
      .push_data (push_data),
      .pop       (rsp_ready),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign rsp_valid = ~empty;
   assign rsp_rdata = head.rdata;
   assign rsp_err   = head.err;
   assign rsp_we    = head.we;

endmodule

// File: tb/tb_dvip_bram_req_bridge.sv
// Directed bench for dvip_bram_req_bridge with a behavioural byte-write RAM behind it.
module tb_dvip_bram_req_bridge;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_we;
   logic        ram_cs;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [31:0] ram_wstrb;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;
   logic        ram_ready;

   logic        preload;
   logic [31:0] ram_mem [1024];
   logic [31:0] ref_mem [32];

   int          checks;
   int          failures;
   int          got;
   int          nextw;
   int          w;
   logic        acc;
   logic        wr;
   logic        oor_sel;
   logic [3:0]  be_r;
   logic [31:0] wd_r;
   logic [15:0] a_r;
   logic [33:0] exp_e;
   logic [33:0] exp_q [$];

   dvip_bram_req_bridge dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .rsp_we    (rsp_we),
      .ram_cs    (ram_cs),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wstrb (ram_wstrb),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .ram_ready (ram_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: bit-strobed writes, one-cycle read latency, output held between reads.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) begin
            ram_mem[i] <= 32'hA500_0000 | 32'(i);
         end
         ram_dout <= '0;
      end else if (ram_cs) begin
         if (ram_we) begin
            ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_wstrb) | (ram_din & ram_wstrb);
         end else begin
            ram_dout <= ram_mem[ram_addr];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic we, input logic [15:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata);
      req_valid = v;
      req_we    = we;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      preload   = 1'b1;
      rsp_ready = 1'b1;
      ram_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ref_mem[i] = 32'hA500_0000 | 32'(i);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);

      // Reset state
      tick();
      tick();
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      preload = 1'b0;
      rst     = 1'b0;
      #1;
      checkOutput("post_rst_req_ready", req_ready, 1);
      checkOutput("post_rst_rsp_valid", rsp_valid, 0);
      checkOutput("post_rst_ram_cs", ram_cs, 0);

      // Full write then read of word 4
      applyStimulus(1'b1, 1'b1, 16'h0010, 4'hF, 32'h1122_3344);
      checkOutput("wr_ram_cs", ram_cs, 1);
      checkOutput("wr_ram_we", ram_we, 1);
      checkOutput("wr_ram_addr", ram_addr, 4);
      checkOutput("wr_ram_wstrb", ram_wstrb, 32'hFFFF_FFFF);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0010, 4'h0, 32'h0);
      checkOutput("rd_ram_cs", ram_cs, 1);
      checkOutput("rd_ram_we", ram_we, 0);
      checkOutput("rd_no_rsp_yet", rsp_valid, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      checkOutput("idle_ram_cs", ram_cs, 0);
      checkOutput("wr_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_we}, {1'b1, 32'h0, 1'b0, 1'b1});
      tick();
      checkOutput("rd_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_we}, {1'b1, 32'h1122_3344, 1'b0, 1'b0});
      tick();
      checkOutput("empty_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_we}, 35'h0);

      // Partial write with byte enables 0101
      applyStimulus(1'b1, 1'b1, 16'h0010, 4'b0101, 32'hAABB_CCDD);
      checkOutput("pw_ram_wstrb", ram_wstrb, 32'h00FF_00FF);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0010, 4'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      checkOutput("pw_rsp_we", rsp_we, 1);
      tick();
      checkOutput("pw_rd_rdata", rsp_rdata, 32'h11BB_33DD);
      tick();

      // Out-of-range requests, including one that would alias if truncated
      applyStimulus(1'b1, 1'b0, 16'h1000, 4'h0, 32'h0);
      checkOutput("oor_ram_cs", ram_cs, 0);
      checkOutput("oor_req_ready", req_ready, 1);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h4010, 4'h0, 32'h0);
      checkOutput("oor_alias_ram_cs", ram_cs, 0);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0FFC, 4'h0, 32'h0);
      checkOutput("top_word_ram_cs", ram_cs, 1);
      checkOutput("top_word_ram_addr", ram_addr, 10'h3FF);
      checkOutput("oor_rsp0", {rsp_valid, rsp_rdata, rsp_err, rsp_we}, {1'b1, 32'h0, 1'b1, 1'b0});
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0014, 4'h0, 32'h0);
      checkOutput("w5_ram_addr", ram_addr, 5);
      checkOutput("oor_rsp1", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'h0, 1'b1});
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      checkOutput("top_word_rsp", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'hA500_03FF, 1'b0});
      tick();
      checkOutput("after_oor_rsp", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'hA500_0005, 1'b0});
      tick();
      checkOutput("oor_drained", rsp_valid, 0);

      // RAM not ready blocks acceptance
      ram_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 16'h0014, 4'h0, 32'h0);
      checkOutput("rr_req_ready", req_ready, 0);
      checkOutput("rr_ram_cs", ram_cs, 0);
      tick();
      checkOutput("rr_no_rsp", rsp_valid, 0);
      ram_ready = 1'b1;
      #1;
      checkOutput("rr_resume_ready", req_ready, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      tick();
      checkOutput("rr_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'hA500_0005});
      tick();

      // Backpressure: five reads of words 6..10 with the consumer stalled
      rsp_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 16'h0018, 4'h0, 32'h0);
      checkOutput("bp_ready0", req_ready, 1);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h001C, 4'h0, 32'h0);
      checkOutput("bp_ready1", req_ready, 1);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0020, 4'h0, 32'h0);
      checkOutput("bp_ready2", req_ready, 1);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0024, 4'h0, 32'h0);
      checkOutput("bp_ready3", req_ready, 0);
      checkOutput("bp_ram_cs3", ram_cs, 0);
      tick();
      checkOutput("bp_ready4", req_ready, 0);
      checkOutput("bp_head", {rsp_valid, rsp_rdata}, {1'b1, 32'hA500_0006});
      tick();
      checkOutput("bp_head_stable", {rsp_valid, rsp_rdata, rsp_err, rsp_we}, {1'b1, 32'hA500_0006, 1'b0, 1'b0});
      rsp_ready = 1'b1;
      #1;
      checkOutput("bp_no_same_cycle_credit", req_ready, 0);
      got   = 0;
      nextw = 9;
      for (int c = 0; c < 20 && got < 5; c++) begin
         if (rsp_valid) begin
            checkOutput("bp_rsp", rsp_rdata, 32'hA500_0006 + 32'(got));
            got++;
         end
         acc = req_valid & req_ready;
         tick();
         if (acc) nextw++;
         if (nextw <= 10) applyStimulus(1'b1, 1'b0, 16'(nextw * 4), 4'h0, 32'h0);
         else             applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      end
      checkOutput("bp_count", got, 5);
      checkOutput("bp_no_extra", rsp_valid, 0);

      // Reset with two responses queued and one pending
      rsp_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 16'h0018, 4'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h001C, 4'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 16'h0020, 4'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      checkOutput("mr_pre_valid", rsp_valid, 1);
      rst = 1'b1;
      #1;
      checkOutput("mr_rsp_valid", rsp_valid, 0);
      checkOutput("mr_req_ready", req_ready, 0);
      tick();
      rst       = 1'b0;
      rsp_ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0014, 4'h0, 32'h0);
      checkOutput("mr_post_ready", req_ready, 1);
      checkOutput("mr_post_valid", rsp_valid, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      checkOutput("mr_no_stale", rsp_valid, 0);
      tick();
      checkOutput("mr_w5_rsp", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'hA500_0005, 1'b0});
      tick();
      checkOutput("mr_drained", rsp_valid, 0);

      // Throughput: 100 random operations on words 16..31, occasional out-of-range
      for (int i = 0; i < 100; i++) begin
         w       = 16 + int'($urandom_range(15));
         wr      = 1'($urandom_range(1));
         be_r    = 4'($urandom_range(15, 1));
         wd_r    = $urandom;
         oor_sel = ($urandom_range(9) == 0);
         a_r     = oor_sel ? 16'((1024 + w) * 4) : 16'(w * 4);
         applyStimulus(1'b1, wr, a_r, be_r, wd_r);
         checkOutput("tput_ready", req_ready, 1);
         checkOutput("tput_valid", rsp_valid, (i >= 2) ? 1 : 0);
         if (oor_sel) begin
            exp_e = {32'h0, 1'b1, wr};
         end else if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (be_r[b]) ref_mem[w][b*8 +: 8] = wd_r[b*8 +: 8];
            end
            exp_e = {32'h0, 1'b0, 1'b1};
         end else begin
            exp_e = {ref_mem[w], 1'b0, 1'b0};
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) checkOutput("tput_unexpected_rsp", 1, 0);
            else checkOutput("tput_rsp", {rsp_rdata, rsp_err, rsp_we}, exp_q.pop_front());
         end
         exp_q.push_back(exp_e);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      for (int c = 0; c < 10; c++) begin
         if (exp_q.size() == 0) break;
         if (rsp_valid) checkOutput("tput_rsp_drain", {rsp_rdata, rsp_err, rsp_we}, exp_q.pop_front());
         tick();
      end
      checkOutput("tput_all_received", exp_q.size(), 0);
      checkOutput("tput_end_empty", rsp_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
